// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial frame generator/receiver pair.
package serial_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam int         DEF_WORD_W   = 8;
    localparam logic [7:0] DEF_SYNC_PAT = 8'hA5;
    localparam int         SYNC_CNT_W   = 8;

    // Saturating increment for the sync counter (holds at all-ones).
    function automatic logic [SYNC_CNT_W-1:0] sat_inc(input logic [SYNC_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Enabled MSB-first shift register with look-ahead next value and a
// saturating count of bits accepted since the last clear.
module serial_shift_reg
    import serial_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic                       i_din,
    input  logic                       i_fill_clr,
    output logic [WORD_W-1:0]          o_nxt,
    output logic [$clog2(WORD_W+1)-1:0] o_fill_cnt
);

    localparam int FILL_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_sr;
    logic [FILL_W-1:0] r_fill_cnt;

    assign o_nxt      = {r_sr[WORD_W-2:0], i_din};
    assign o_fill_cnt = r_fill_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= o_nxt;
        end
    end

    // Clear wins over a simultaneous accepted bit so a new hunt starts empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fill_cnt <= '0;
        end else if (i_fill_clr) begin
            r_fill_cnt <= '0;
        end else if (i_en && (r_fill_cnt != FILL_W'(WORD_W))) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for a sync word, then deserializes
// FRAME_WORDS MSB-first words with a one-cycle valid strobe per word.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int                WORD_W      = DEF_WORD_W,
    parameter logic [WORD_W-1:0] SYNC_PAT    = WORD_W'(DEF_SYNC_PAT),
    parameter int                FRAME_WORDS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  din_en,
    output logic [WORD_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  sync_locked,
    output logic                  frame_done,
    output logic [SYNC_CNT_W-1:0] sync_count
);

    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WC_W   = $clog2(FRAME_WORDS + 1);
    localparam int FILL_W = $clog2(WORD_W + 1);

    state_t                r_state;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [WC_W-1:0]       r_word_cnt;
    logic [WORD_W-1:0]     r_dout;
    logic                  r_dout_valid;
    logic                  r_sync_locked;
    logic                  r_frame_done;
    logic [SYNC_CNT_W-1:0] r_sync_count;

    state_t                w_state_nxt;
    logic [BIT_W-1:0]      w_bit_cnt_nxt;
    logic [WC_W-1:0]       w_word_cnt_nxt;
    logic [WORD_W-1:0]     w_dout_nxt;
    logic                  w_dout_valid_nxt;
    logic                  w_sync_locked_nxt;
    logic                  w_frame_done_nxt;
    logic [SYNC_CNT_W-1:0] w_sync_count_nxt;
    logic                  w_fill_clr;

    logic [WORD_W-1:0]     w_nxt;
    logic [FILL_W-1:0]     w_fill_cnt;
    logic                  w_fill_ok;
    logic                  w_sync_hit;
    logic                  w_last_bit;
    logic                  w_last_word;

    serial_shift_reg #(
        .WORD_W (WORD_W)
    ) u_shift (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (din_en),
        .i_din      (din),
        .i_fill_clr (w_fill_clr),
        .o_nxt      (w_nxt),
        .o_fill_cnt (w_fill_cnt)
    );

    // The incoming bit completes a full window only once WORD_W-1 bits are already held.
    assign w_fill_ok   = (w_fill_cnt >= FILL_W'(WORD_W - 1));
    assign w_sync_hit  = din_en && (w_nxt == SYNC_PAT) && w_fill_ok;
    assign w_last_bit  = (r_bit_cnt == BIT_W'(WORD_W - 1));
    assign w_last_word = (r_word_cnt == WC_W'(FRAME_WORDS - 1));

    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_word_cnt_nxt    = r_word_cnt;
        w_dout_nxt        = r_dout;
        w_dout_valid_nxt  = 1'b0;
        w_sync_locked_nxt = r_sync_locked;
        w_frame_done_nxt  = 1'b0;
        w_sync_count_nxt  = r_sync_count;
        w_fill_clr        = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_sync_hit) begin
                    w_state_nxt       = DATA;
                    w_bit_cnt_nxt     = '0;
                    w_word_cnt_nxt    = '0;
                    w_sync_locked_nxt = 1'b1;
                    w_sync_count_nxt  = sat_inc(r_sync_count);
                end
            end
            DATA: begin
                if (din_en) begin
                    if (w_last_bit) begin
                        w_dout_nxt       = w_nxt;
                        w_dout_valid_nxt = 1'b1;
                        w_bit_cnt_nxt    = '0;
                        w_word_cnt_nxt   = r_word_cnt + 1'b1;
                        if (w_last_word) begin
                            w_frame_done_nxt  = 1'b1;
                            w_state_nxt       = HUNT;
                            w_sync_locked_nxt = 1'b0;
                            w_fill_clr        = 1'b1;
                            w_word_cnt_nxt    = '0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_sync_locked <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sync_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_word_cnt    <= w_word_cnt_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_valid  <= w_dout_valid_nxt;
            r_sync_locked <= w_sync_locked_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_sync_count  <= w_sync_count_nxt;
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign sync_locked = r_sync_locked;
    assign frame_done  = r_frame_done;
    assign sync_count  = r_sync_count;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: one-word and two-word frame instances
// driven by a shared stream and compared every cycle against a bit-level model.
module tb_serial_frame_receiver;

    localparam int         W    = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic [7:0] dout1, dout2, sc1, sc2;
    logic       v1, v2, l1, l2, f1, f2;

    always #5 clk = ~clk;

    serial_frame_receiver #(.WORD_W(W), .SYNC_PAT(SYNC), .FRAME_WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en),
        .dout(dout1), .dout_valid(v1), .sync_locked(l1),
        .frame_done(f1), .sync_count(sc1)
    );

    serial_frame_receiver #(.WORD_W(W), .SYNC_PAT(SYNC), .FRAME_WORDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en),
        .dout(dout2), .dout_valid(v2), .sync_locked(l2),
        .frame_done(f2), .sync_count(sc2)
    );

    int n_chk = 0;
    int n_bad = 0;
    int vcount1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: window of recent bits while hunting, word assembly while locked.
    int fw [2] = '{1, 2};
    int m_locked [2];
    int m_hcnt [2];
    int m_hval [2];
    int m_dcnt [2];
    int m_dval [2];
    int m_words [2];
    int m_dout [2];
    int m_valid [2];
    int m_fd [2];
    int m_sc [2];

    task automatic model_step(input int k, input logic r, input logic d, input logic e);
        if (!r) begin
            m_locked[k] = 0; m_hcnt[k] = 0; m_hval[k] = 0; m_dcnt[k] = 0;
            m_dval[k] = 0; m_words[k] = 0; m_dout[k] = 0; m_valid[k] = 0;
            m_fd[k] = 0; m_sc[k] = 0;
        end else begin
            m_valid[k] = 0;
            m_fd[k] = 0;
            if (e) begin
                if (m_locked[k] == 0) begin
                    m_hval[k] = (m_hval[k] * 2 + int'(d)) % 256;
                    if (m_hcnt[k] < W) m_hcnt[k]++;
                    if (m_hcnt[k] == W && m_hval[k] == int'(SYNC)) begin
                        m_locked[k] = 1;
                        m_sc[k] = (m_sc[k] < 255) ? m_sc[k] + 1 : 255;
                        m_dcnt[k] = 0; m_dval[k] = 0; m_words[k] = 0;
                    end
                end else begin
                    m_dval[k] = m_dval[k] * 2 + int'(d);
                    m_dcnt[k]++;
                    if (m_dcnt[k] == W) begin
                        m_dout[k] = m_dval[k];
                        m_valid[k] = 1;
                        m_dcnt[k] = 0; m_dval[k] = 0;
                        m_words[k]++;
                        if (m_words[k] == fw[k]) begin
                            m_fd[k] = 1; m_locked[k] = 0; m_hcnt[k] = 0; m_words[k] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] d, input logic v,
                             input logic l, input logic f, input logic [7:0] sc);
        chk($sformatf("d%0d_dout", k), 32'(d), 32'(m_dout[k]));
        chk($sformatf("d%0d_valid", k), 32'(v), 32'(m_valid[k]));
        chk($sformatf("d%0d_locked", k), 32'(l), 32'(m_locked[k]));
        chk($sformatf("d%0d_frame_done", k), 32'(f), 32'(m_fd[k]));
        chk($sformatf("d%0d_sync_count", k), 32'(sc), 32'(m_sc[k]));
    endtask

    task automatic cyc(input logic r, input logic d, input logic e);
        rst_n = r; din = d; din_en = e;
        model_step(0, r, d, e);
        model_step(1, r, d, e);
        @(posedge clk);
        #1;
        check_dut(0, dout1, v1, l1, f1, sc1);
        check_dut(1, dout2, v2, l2, f2, sc2);
        if (v1) vcount1++;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            if (gap) cyc(1'b1, 1'($urandom), 1'b0);
            cyc(1'b1, b[i], 1'b1);
        end
    endtask

    initial begin
        logic [7:0] rb;
        // Reset with toggling data, then idle zeros
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i % 2), 1'b1);
        chk("rst_dout", 32'(dout1), 32'h0);
        chk("rst_valid", 32'(v1), 32'h0);
        chk("rst_locked", 32'(l1), 32'h0);
        chk("rst_sc", 32'(sc2), 32'h0);
        vcount1 = 0;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("idle_valid_count", 32'(vcount1), 32'h0);
        chk("idle_sc", 32'(sc1), 32'h0);

        // Basic frame
        cyc(1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0);
        chk("basic_lock", 32'(l1), 32'h1);
        chk("basic_sc", 32'(sc1), 32'h1);
        send_byte(8'h3C, 1'b0);
        chk("basic_dout", 32'(dout1), 32'h3C);
        chk("basic_valid", 32'(v1), 32'h1);
        chk("basic_fd", 32'(f1), 32'h1);
        chk("basic_unlock", 32'(l1), 32'h0);

        // Gapped enable
        cyc(1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        chk("gap_dout", 32'(dout1), 32'h3C);
        chk("gap_valid", 32'(v1), 32'h1);
        cyc(1'b1, 1'($urandom), 1'b0);
        chk("gap_valid_pulse", 32'(v1), 32'h0);

        // Two-word frame with sync pattern inside data
        cyc(1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        chk("multi_w1_dout", 32'(dout2), 32'hA5);
        chk("multi_w1_valid", 32'(v2), 32'h1);
        chk("multi_w1_fd", 32'(f2), 32'h0);
        send_byte(8'h5A, 1'b0);
        chk("multi_w2_dout", 32'(dout2), 32'h5A);
        chk("multi_w2_fd", 32'(f2), 32'h1);
        chk("multi_sc", 32'(sc2), 32'h1);

        // Overlap prefix then reset mid-frame
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        rb = 8'hA5;
        for (int i = 7; i >= 1; i--) cyc(1'b1, rb[i], 1'b1);
        chk("ovl_not_yet", 32'(l1), 32'h0);
        cyc(1'b1, rb[0], 1'b1);
        chk("ovl_lock", 32'(l1), 32'h1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("midrst_valid", 32'(v1), 32'h0);
        chk("midrst_locked", 32'(l1), 32'h0);
        chk("midrst_sc", 32'(sc1), 32'h0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hFF, 1'b0);
        chk("resend_dout", 32'(dout1), 32'hFF);
        chk("resend_valid", 32'(v1), 32'h1);

        // Sync counter saturation
        cyc(1'b0, 1'b0, 1'b0);
        vcount1 = 0;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5, 1'b0);
            send_byte(8'h00, 1'b0);
        end
        chk("sat_sc", 32'(sc1), 32'd255);
        chk("sat_valid_count", 32'(vcount1), 32'd300);

        // Randomized stream with injected sync words, gaps and rare resets
        cyc(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            rb = ($urandom % 3 == 0) ? SYNC : 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                if ($urandom % 4 == 0) cyc(1'b1, 1'($urandom), 1'b0);
                cyc(($urandom % 200) != 0, rb[i], 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
